// File: rtl/sipo_pkg.sv
// Shared types and constants for the framed SIPO receiver.
// Optional parity support is selected with SIPO_FRAME_RX_PARITY_EN.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic FRAME_START_BIT = 1'b1;

  // Even parity holds when the XOR over data plus parity bit is zero.
  function automatic logic even_parity_ok(input logic [32:0] v);
    return ((^v) == 1'b0);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Single-entry valid/ready holding register with load, drain and sticky overrun.
module sipo_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_ready,
  input  logic              i_ovf_clr,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  output logic              o_ovf
);

  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_ovf;
  logic              w_drain;
  logic              w_accept;

  assign w_drain  = r_valid & i_ready;
  // A load fits when the entry is empty or is being drained on the same edge.
  assign w_accept = i_load & (~r_valid | i_ready);

  // Holding entry and sticky overrun flag; a new overrun wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dout  <= i_word;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (i_load && !w_accept) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial-to-parallel receiver: start bit, DATA_W bits LSB-first, optional
// even parity bit (SIPO_FRAME_RX_PARITY_EN), then a valid/ready holding register.
module sipo_frame_rx
  import sipo_pkg::*;
#(
  parameter int  DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              par_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_busy;
  logic              r_par_err;
  logic              w_par_err_nxt;
  logic              w_complete;
  logic [DATA_W-1:0] w_word;

  // Frame state register and assembly datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_par_err <= w_par_err_nxt;
    end
  end

  // Next-state, shift and completion decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_complete    = 1'b0;
    w_word        = r_shift;
    w_par_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (si == FRAME_START_BIT) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        w_shift_nxt = {si, r_shift[DATA_W-1:1]};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = IDLE;
          w_complete  = 1'b1;
          w_word      = w_shift_nxt;
`endif
        end else begin
          w_state_nxt = DATA;
        end
      end
`ifdef SIPO_FRAME_RX_PARITY_EN
      PARITY: begin
        w_state_nxt = IDLE;
        if (even_parity_ok(33'({si, r_shift}))) begin
          w_complete = 1'b1;
        end else begin
          w_par_err_nxt = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  sipo_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_complete),
    .i_word    (w_word),
    .i_ready   (dout_ready),
    .i_ovf_clr (ovf_clr),
    .o_dout    (dout),
    .o_valid   (dout_valid),
    .o_ovf     (ovf)
  );

  assign busy    = r_busy;
  assign par_err = r_par_err;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed, table-driven bench for sipo_frame_rx (DATA_W=8); follows SIPO_FRAME_RX_PARITY_EN.
module tb_sipo_frame_rx;

  typedef struct {
    logic       si;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       si = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic       par_err;

  int n_total = 0;
  int n_pass  = 0;
  vec_t tbl[$];

  sipo_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic s, input logic r, input logic c, input logic ev,
                      input logic [7:0] ed, input logic eb, input logic eo);
    vec_t v;
    v.si = s; v.rdy = r; v.clr = c; v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
    tbl.push_back(v);
  endtask

  // Start bit + 8 data bits (+ good parity bit); mid rows keep the prior outputs.
  task automatic add_frame(input logic [7:0] d, input logic r,
                           input logic ev_m, input logic [7:0] ed_m, input logic eo_m,
                           input logic ev_e, input logic [7:0] ed_e, input logic eo_e);
    push(1'b1, r, 1'b0, ev_m, ed_m, 1'b1, eo_m);
    for (int i = 0; i < 7; i++) push(d[i], r, 1'b0, ev_m, ed_m, 1'b1, eo_m);
`ifdef SIPO_FRAME_RX_PARITY_EN
    push(d[7], r, 1'b0, ev_m, ed_m, 1'b1, eo_m);
    push(^d, r, 1'b0, ev_e, ed_e, 1'b0, eo_e);
`else
    push(d[7], r, 1'b0, ev_e, ed_e, 1'b0, eo_e);
`endif
  endtask

  task automatic step(input logic s, input logic r);
    si = s; dout_ready = r; ovf_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_steps(input logic [7:0] d, input logic r_body, input logic r_last,
                             input logic par_good);
    logic last_ready;
    step(1'b1, r_body);
    for (int i = 0; i < 8; i++) begin
      last_ready = r_body;
`ifndef SIPO_FRAME_RX_PARITY_EN
      if (i == 7) last_ready = r_last;
`endif
      step(d[i], last_ready);
    end
`ifdef SIPO_FRAME_RX_PARITY_EN
    step(par_good ? ^d : ~(^d), r_last);
`endif
  endtask

  initial begin
    logic [7:0] pat;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    rst = 1'b0;

    // A5 with ready high, one-cycle valid
    add_frame(8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
    // Idle line
    for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
    // Backpressure: 3C held, FF dropped with overrun, clear, then drain
    add_frame(8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0);
    add_frame(8'hFF, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      si = tbl[i].si; dout_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), {31'd0, dout_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_dout", i), {24'd0, dout}, {24'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].eo});
      chk($sformatf("tbl%0d_par_err", i), {31'd0, par_err}, 32'd0);
    end

    // Simultaneous drain and load
    frame_steps(8'h11, 1'b0, 1'b0, 1'b1);
    chk("hold11_valid", {31'd0, dout_valid}, 32'd1);
    chk("hold11_dout", {24'd0, dout}, 32'h11);
    frame_steps(8'h22, 1'b0, 1'b1, 1'b1);
    chk("swap_valid", {31'd0, dout_valid}, 32'd1);
    chk("swap_dout", {24'd0, dout}, 32'h22);
    chk("swap_ovf", {31'd0, ovf}, 32'd0);
    step(1'b0, 1'b1);
    chk("swap_drain_valid", {31'd0, dout_valid}, 32'd0);
    chk("swap_drain_dout", {24'd0, dout}, 32'h22);

    // Reset mid-frame, then a clean frame
    step(1'b1, 1'b0);
    pat = 8'hFF;
    for (int i = 0; i < 4; i++) step(pat[i], 1'b0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    si = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    frame_steps(8'h5A, 1'b1, 1'b1, 1'b1);
    chk("post_rst_valid", {31'd0, dout_valid}, 32'd1);
    chk("post_rst_dout", {24'd0, dout}, 32'h5A);
    chk("post_rst_ovf", {31'd0, ovf}, 32'd0);
    step(1'b0, 1'b1);
    chk("post_rst_drain", {31'd0, dout_valid}, 32'd0);

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Good parity loads, bad parity drops with a one-cycle error pulse
    frame_steps(8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_ok_valid", {31'd0, dout_valid}, 32'd1);
    chk("par_ok_dout", {24'd0, dout}, 32'h07);
    chk("par_ok_err", {31'd0, par_err}, 32'd0);
    step(1'b0, 1'b1);
    chk("par_ok_drain", {31'd0, dout_valid}, 32'd0);
    frame_steps(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_bad_valid", {31'd0, dout_valid}, 32'd0);
    chk("par_bad_err", {31'd0, par_err}, 32'd1);
    chk("par_bad_ovf", {31'd0, ovf}, 32'd0);
    step(1'b0, 1'b1);
    chk("par_bad_err_clr", {31'd0, par_err}, 32'd0);
    chk("par_bad_valid2", {31'd0, dout_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
